// File: rtl/cache_pkg.sv
// Shared definitions for the cache / write-buffer / memory slice.
package cache_pkg;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 8;
  localparam int LINE_LSB = 4;
  localparam int LINE_W   = ADDR_W - LINE_LSB;

  // Byte address field layout: tag 9:6, index 5:4, word 3:2, byte 1:0
  localparam int TAG_MSB  = 9;
  localparam int TAG_LSB  = 6;
  localparam int IDX_MSB  = 5;
  localparam int IDX_LSB  = 4;
  localparam int WORD_MSB = 3;
  localparam int WORD_LSB = 2;
  localparam int BYTE_MSB = 1;
  localparam int BYTE_LSB = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } drain_state_t;

  // Line number of a byte address (tag + index bits)
  function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:LINE_LSB];
  endfunction

endpackage

// File: rtl/wb_entry_array.sv
// Circular storage for the write buffer: entries, valid bits, head/tail
// pointers, occupancy count and the parallel line-address compare.
module wb_entry_array
  import cache_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_push,
  input  logic [ADDR_W-1:0]          i_push_addr,
  input  logic [DATA_W-1:0]          i_push_data,
  input  logic                       i_pop,
  input  logic                       i_coal,
  input  logic [DATA_W-1:0]          i_coal_data,
  input  logic [LINE_W-1:0]          i_chk_line,
  output logic [ADDR_W-1:0]          o_head_addr,
  output logic [DATA_W-1:0]          o_head_data,
  output logic [ADDR_W-1:0]          o_newest_addr,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_chk_hit
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  w_newest_ptr;
  logic              w_hit;

  // Newest entry sits just behind the tail; power-of-two depth wraps for free
  assign w_newest_ptr  = r_tail - PTR_W'(1);
  assign o_head_addr   = r_addr[r_head];
  assign o_head_data   = r_data[r_head];
  assign o_newest_addr = r_addr[w_newest_ptr];
  assign o_count       = r_count;
  assign o_chk_hit     = w_hit;

  // Enqueue at tail, coalesce into newest, pop from head, track occupancy
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_addr[r_tail]  <= i_push_addr;
        r_data[r_tail]  <= i_push_data;
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
      end
      if (i_coal) begin
        r_data[w_newest_ptr] <= i_coal_data;
      end
      if (i_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Any valid entry (in-flight head included) on the requested line
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (line_of(r_addr[i]) == i_chk_line)) begin
        w_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/write_buffer.sv
// Byte write buffer between the write-through cache and main memory.
// Holds the drain FSM, the coalescing decision and both handshakes.
module write_buffer
  import cache_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_wr_valid,
  output logic                       o_wr_ready,
  input  logic [ADDR_W-1:0]          i_wr_addr,
  input  logic [DATA_W-1:0]          i_wr_data,
  output logic                       o_mem_req,
  output logic [ADDR_W-1:0]          o_mem_addr,
  output logic [DATA_W-1:0]          o_mem_data,
  input  logic                       i_mem_ack,
  input  logic [LINE_W-1:0]          i_chk_line,
  output logic                       o_chk_hit,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int CNT_W = $clog2(DEPTH+1);

  drain_state_t      r_state;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data;

  logic [CNT_W-1:0]  w_count;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic [ADDR_W-1:0] w_newest_addr;
  logic              w_empty;
  logic              w_full;
  logic              w_ready;
  logic              w_coal;
  logic              w_push;
  logic              w_pop;
  logic              w_chk_hit;

  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == CNT_W'(DEPTH));
  assign w_ready = !w_full;

  // With a single entry the newest is the head, which is either in flight
  // or being latched for memory this edge, so it must never be rewritten.
  assign w_coal  = i_wr_valid && (w_count > CNT_W'(1)) && (i_wr_addr == w_newest_addr);
  assign w_push  = i_wr_valid && w_ready && !w_coal;
  assign w_pop   = (r_state == ST_BUSY) && i_mem_ack;

  wb_entry_array #(
    .DEPTH(DEPTH)
  ) u_entries (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_push       (w_push),
    .i_push_addr  (i_wr_addr),
    .i_push_data  (i_wr_data),
    .i_pop        (w_pop),
    .i_coal       (w_coal),
    .i_coal_data  (i_wr_data),
    .i_chk_line   (i_chk_line),
    .o_head_addr  (w_head_addr),
    .o_head_data  (w_head_data),
    .o_newest_addr(w_newest_addr),
    .o_count      (w_count),
    .o_chk_hit    (w_chk_hit)
  );

  // Drain FSM: latch head, hold request stable until memory acknowledges
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_mem_addr <= w_head_addr;
            r_mem_data <= w_head_data;
            r_mem_req  <= 1'b1;
            r_state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (i_mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_wr_ready = w_ready;
  assign o_mem_req  = r_mem_req;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_data = r_mem_data;
  assign o_chk_hit  = w_chk_hit;
  assign o_empty    = w_empty;
  assign o_full     = w_full;
  assign o_count    = w_count;

endmodule

// File: tb/tb_write_buffer.sv
// Directed self-checking bench for write_buffer.
module tb_write_buffer;
  import cache_pkg::*;

  logic              clk;
  logic              reset;
  logic              wrValid;
  logic              wrReady;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;
  logic              memReq;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memData;
  logic              memAck;
  logic [LINE_W-1:0] chkLine;
  logic              chkHit;
  logic              empty;
  logic              full;
  logic [2:0]        count;

  int nAsserts = 0;
  int nFails   = 0;

  write_buffer #(.DEPTH(4)) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_wr_valid(wrValid),
    .o_wr_ready(wrReady),
    .i_wr_addr (wrAddr),
    .i_wr_data (wrData),
    .o_mem_req (memReq),
    .o_mem_addr(memAddr),
    .o_mem_data(memData),
    .i_mem_ack (memAck),
    .i_chk_line(chkLine),
    .o_chk_hit (chkHit),
    .o_empty   (empty),
    .o_full    (full),
    .o_count   (count)
  );

  // 10 time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value with its expected value
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present one write for a single cycle, then release it
  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    wrValid = 1'b1;
    wrAddr  = addr;
    wrData  = data;
    tick();
    wrValid = 1'b0;
  endtask

  // Wait (bounded) for a memory request, check it, then acknowledge it
  task automatic drainOne(input string tag, input logic [ADDR_W-1:0] expAddr,
                          input logic [DATA_W-1:0] expData);
    for (int i = 0; i < 10; i++) begin
      if (memReq !== 1'b1) tick();
    end
    checkOutput({tag, "_req"}, 32'(memReq), 32'd1);
    checkOutput({tag, "_addr"}, 32'(memAddr), 32'(expAddr));
    checkOutput({tag, "_data"}, 32'(memData), 32'(expData));
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    wrValid = 1'b0;
    wrAddr  = '0;
    wrData  = '0;
    memAck  = 1'b0;
    chkLine = '0;
    tick();
    tick();
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_ready", 32'(wrReady), 32'd1);
    checkOutput("rst_req", 32'(memReq), 32'd0);
    checkOutput("rst_maddr", 32'(memAddr), 32'd0);
    checkOutput("rst_mdata", 32'(memData), 32'd0);

    $display("[TB] single write");
    applyStimulus(10'b0000010100, 8'hAB);
    checkOutput("single_count1", 32'(count), 32'd1);
    checkOutput("single_req_c1", 32'(memReq), 32'd0);
    tick();
    checkOutput("single_req_c2", 32'(memReq), 32'd1);
    checkOutput("single_maddr", 32'(memAddr), 32'h014);
    checkOutput("single_mdata", 32'(memData), 32'hAB);
    tick();
    tick();
    checkOutput("single_req_hold", 32'(memReq), 32'd1);
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    checkOutput("single_empty", 32'(empty), 32'd1);
    checkOutput("single_req_drop", 32'(memReq), 32'd0);

    $display("[TB] fill to full");
    applyStimulus(10'h000, 8'hA0);
    applyStimulus(10'h011, 8'hA1);
    applyStimulus(10'h022, 8'hA2);
    applyStimulus(10'h033, 8'hA3);
    checkOutput("full_count", 32'(count), 32'd4);
    checkOutput("full_flag", 32'(full), 32'd1);
    checkOutput("full_ready", 32'(wrReady), 32'd0);
    applyStimulus(10'h044, 8'hA4);
    checkOutput("full_reject", 32'(count), 32'd4);
    drainOne("full_d0", 10'h000, 8'hA0);
    drainOne("full_d1", 10'h011, 8'hA1);
    drainOne("full_d2", 10'h022, 8'hA2);
    drainOne("full_d3", 10'h033, 8'hA3);
    checkOutput("full_drained", 32'(empty), 32'd1);

    $display("[TB] coalesce");
    applyStimulus(10'h000, 8'h50);
    applyStimulus(10'h045, 8'h11);
    checkOutput("coal_count_a", 32'(count), 32'd2);
    applyStimulus(10'h045, 8'h22);
    checkOutput("coal_count_b", 32'(count), 32'd2);
    drainOne("coal_d0", 10'h000, 8'h50);
    drainOne("coal_d1", 10'h045, 8'h22);
    checkOutput("coal_empty", 32'(empty), 32'd1);

    $display("[TB] no coalesce into head");
    applyStimulus(10'h045, 8'h44);
    tick();
    checkOutput("head_busy", 32'(memReq), 32'd1);
    applyStimulus(10'h045, 8'h33);
    checkOutput("head_count", 32'(count), 32'd2);
    drainOne("head_d0", 10'h045, 8'h44);
    drainOne("head_d1", 10'h045, 8'h33);

    $display("[TB] line check");
    applyStimulus(10'h1C4, 8'h77);
    chkLine = 6'h1C;
    #1;
    checkOutput("chk_hit_same", 32'(chkHit), 32'd1);
    chkLine = 6'h1D;
    #1;
    checkOutput("chk_hit_other", 32'(chkHit), 32'd0);
    chkLine = 6'h1C;
    tick();
    checkOutput("chk_inflight_req", 32'(memReq), 32'd1);
    checkOutput("chk_hit_inflight", 32'(chkHit), 32'd1);
    drainOne("chk_d0", 10'h1C4, 8'h77);
    checkOutput("chk_hit_after_ack", 32'(chkHit), 32'd0);

    $display("[TB] reset mid-drain");
    applyStimulus(10'h100, 8'h01);
    applyStimulus(10'h104, 8'h02);
    applyStimulus(10'h108, 8'h03);
    checkOutput("midrst_count3", 32'(count), 32'd3);
    checkOutput("midrst_busy", 32'(memReq), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midrst_req", 32'(memReq), 32'd0);
    checkOutput("midrst_count", 32'(count), 32'd0);
    checkOutput("midrst_empty", 32'(empty), 32'd1);
    applyStimulus(10'h200, 8'h99);
    drainOne("midrst_d0", 10'h200, 8'h99);
    checkOutput("midrst_final_empty", 32'(empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
